vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48, horizontal front porch, sync and back porch in pixels.
REQ-003 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 Parameter V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33, vertical front porch, sync and back porch in lines.
REQ-005 Parameter HS_POL / VS_POL, default 0 / 0, sync active level (0 = active-low).
REQ-006 Parameter CLK_DIV, default 2, clk cycles per pixel; legal range 1..16.
REQ-007 Parameter CNT_W, default 11, counter width; SHALL satisfy 2^CNT_W >= H_TOTAL and >= V_TOTAL.
REQ-008 clk  input  1  system clock; all state on its rising edge.
REQ-009 rst  input  1  asynchronous, active-low reset.
REQ-010 pix_r / pix_g / pix_b  input  3/3/2  pixel colour for the coordinate presented on x/y.
REQ-011 pattern_sel  input  1  selects the test pattern when the feature is compiled in (see REQ-033).
REQ-012 x / y  output  CNT_W  coordinate currently requested (stage 1).
REQ-013 pix_ce  output  1  one-clk pulse marking each pixel tick.
REQ-014 R / G / B  output  3/3/2  registered colour (stage 2).
REQ-015 HS / VS  output  1  registered sync (stage 2).
REQ-016 de  output  1  registered display-enable (stage 2).
REQ-017 frame_start  output  1  one-clk pulse on the first pixel tick of each frame.

Function
REQ-018 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
REQ-019 A divider counter SHALL assert pix_ce for one clk every CLK_DIV clks; CLK_DIV=1 holds pix_ce high continuously.
REQ-020 On each pix_ce, x SHALL increment; at x = H_TOTAL-1 it SHALL wrap to 0 and y SHALL increment.
REQ-021 y SHALL wrap from V_TOTAL-1 to 0 on the same tick on which x wraps.
REQ-022 Between pix_ce pulses, x, y and all stage-2 outputs SHALL hold.
REQ-023 Stage 2 SHALL update on each pix_ce from the stage-1 values held before that tick, giving a fixed latency of one pixel tick from x/y to HS/VS/de/RGB.
REQ-024 The HS active level SHALL be driven for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], else the inactive level.
REQ-025 The VS active level SHALL be driven for y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], else the inactive level.
REQ-026 de SHALL be 1 only when x < H_ACTIVE and y < V_ACTIVE.
REQ-027 R/G/B SHALL be 0 whenever de would be 0; otherwise the selected colour source.
REQ-028 frame_start SHALL pulse in the clk when stage 2 receives coordinate (0,0).

Reset
REQ-029 While rst=0: divider, x and y = 0; R/G/B = 0; de = 0; frame_start = 0; pix_ce = 0; HS/VS at the inactive level.
REQ-030 Reset assertion SHALL take effect immediately without a clk edge, including mid-line or mid-frame.
REQ-031 After rst deasserts, the first pix_ce SHALL occur CLK_DIV clks later, and the first frame SHALL start at (0,0).

Configuration
REQ-032 Macro VGA_TEST_PATTERN_EN compiles in a built-in colour-bar source.
REQ-033 With VGA_TEST_PATTERN_EN defined and pattern_sel=1, the active-region colour SHALL be bar k = (x*8)/H_ACTIVE: R=3'b111 if k[2], G=3'b111 if k[1], B=2'b11 if k[0], else 0.
REQ-034 With VGA_TEST_PATTERN_EN defined and pattern_sel=0, or with the macro undefined, the colour source SHALL be pix_r/pix_g/pix_b; without the macro, pattern_sel SHALL be ignored.

Verification
REQ-035 Defaults, 20 ns clk, release rst -> pix_ce period 40 ns; HS low for 192 clks; HS period 1600 clks.
REQ-036 Defaults, run one full frame -> VS low for 2 lines (3200 clks); frame_start period 840000 clks; de high for 307200 pixel ticks per frame.
REQ-037 Drive pix_r=7, pix_g=0, pix_b=3 constantly -> R=7, B=3 only while de=1; RGB=0 during blanking; HS edges lag the corresponding x value by exactly one pixel tick.
REQ-038 Assert rst at y=200, x=300 -> all outputs take their reset values within the same clk; after release, the next frame_start occurs after one pixel tick of latency.
REQ-039 Params H_ACTIVE=8, H_FP=H_SYNC=H_BP=2, V_ACTIVE=4, V_FP=V_SYNC=V_BP=1, CLK_DIV=1, HS_POL=1 -> H_TOTAL=14, HS high for x=10..11, and x/y wrap from (13,6) to (0,0).
REQ-040 VGA_TEST_PATTERN_EN defined, pattern_sel=1, defaults -> x=0..79 black, x=80 blue (B=3), x=560 white (R=7, G=7, B=3).

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator.
// Stage 1 presents the pixel coordinate (x, y) being requested. Stage 2 turns
// the previous coordinate into registered HS/VS/de and colour, one pixel tick later.
// Optional feature: define VGA_TEST_PATTERN_EN to compile in an 8-bar colour
// pattern, selected at run time by pattern_sel.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CLK_DIV  = 2,
  parameter int CNT_W    = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       pix_r,
  input  logic [2:0]       pix_g,
  input  logic [1:0]       pix_b,
  input  logic             pattern_sel,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             pix_ce,
  output logic [2:0]       R,
  output logic [2:0]       G,
  output logic [1:0]       B,
  output logic             HS,
  output logic             VS,
  output logic             de,
  output logic             frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // CLK_DIV is at most 16, so a 4-bit divider covers 0..15.
  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic       HS_ON    = 1'(HS_POL);
  localparam logic       VS_ON    = 1'(VS_POL);

`ifdef VGA_TEST_PATTERN_EN
  // Colour bar k = (x*8)/H_ACTIVE: R from k[2], G from k[1], B from k[0].
  function automatic logic [7:0] bar_colour(input logic [CNT_W-1:0] xc);
    logic [CNT_W+2:0] scaled;
    logic [2:0]       k;
    scaled = {xc, 3'b000};
    k      = 3'(scaled / (CNT_W+3)'(H_ACTIVE));
    return {k[2] ? 3'b111 : 3'b000, k[1] ? 3'b111 : 3'b000, k[0] ? 2'b11 : 2'b00};
  endfunction
`endif

  logic [3:0]       div_cnt;
  logic [CNT_W-1:0] x_p1;
  logic [CNT_W-1:0] y_p1;
  logic             vld_p1;
  logic             hs_act_p1;
  logic             vs_act_p1;
  logic             de_nxt_p1;
  logic [7:0]       src_p1;
  logic [2:0]       r_p2;
  logic [2:0]       g_p2;
  logic [1:0]       b_p2;
  logic             hs_p2;
  logic             vs_p2;
  logic             de_p2;
  logic             fs_p2;

  // Pixel-tick divider; pix_ce is registered so it stays low throughout reset
  // and first rises CLK_DIV clocks after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      pix_ce  <= 1'b0;
    end else begin
      pix_ce <= (div_cnt == DIV_LAST);
      if (div_cnt == DIV_LAST) div_cnt <= '0;
      else                     div_cnt <= div_cnt + 4'd1;
    end
  end

  // ---- stage 1: raster coordinate counters ----
  assign vld_p1 = pix_ce;

  // Advance x each pixel tick; y advances (and both wrap) at end of line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_p1 <= '0;
      y_p1 <= '0;
    end else if (vld_p1) begin
      if (x_p1 == H_LAST) begin
        x_p1 <= '0;
        y_p1 <= (y_p1 == V_LAST) ? '0 : y_p1 + CNT_ONE;
      end else begin
        x_p1 <= x_p1 + CNT_ONE;
      end
    end
  end

`ifndef VGA_TEST_PATTERN_EN
  // Without the pattern source the select input has no effect.
  logic unused_pattern_sel;
  assign unused_pattern_sel = pattern_sel;
`endif

  // Decode sync/blanking for the current coordinate and pick the colour source.
  always_comb begin
    hs_act_p1 = (x_p1 >= HS_FIRST) && (x_p1 <= HS_LAST);
    vs_act_p1 = (y_p1 >= VS_FIRST) && (y_p1 <= VS_LAST);
    de_nxt_p1 = (x_p1 < H_ACT_C) && (y_p1 < V_ACT_C);
    src_p1    = {pix_r, pix_g, pix_b};
`ifdef VGA_TEST_PATTERN_EN
    if (pattern_sel) src_p1 = bar_colour(x_p1);
`endif
  end

  // ---- stage 2: registered video outputs ----
  // Capture the stage-1 decode on each pixel tick; colour is blanked outside de.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_p2  <= '0;
      g_p2  <= '0;
      b_p2  <= '0;
      hs_p2 <= ~HS_ON;
      vs_p2 <= ~VS_ON;
      de_p2 <= 1'b0;
      fs_p2 <= 1'b0;
    end else begin
      fs_p2 <= vld_p1 && (x_p1 == '0) && (y_p1 == '0);
      if (vld_p1) begin
        hs_p2 <= hs_act_p1 ? HS_ON : ~HS_ON;
        vs_p2 <= vs_act_p1 ? VS_ON : ~VS_ON;
        de_p2 <= de_nxt_p1;
        {r_p2, g_p2, b_p2} <= de_nxt_p1 ? src_p1 : 8'd0;
      end
    end
  end

  assign x           = x_p1;
  assign y           = y_p1;
  assign R           = r_p2;
  assign G           = g_p2;
  assign B           = b_p2;
  assign HS          = hs_p2;
  assign VS          = vs_p2;
  assign de          = de_p2;
  assign frame_start = fs_p2;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: checks a default-parameter instance (line timing, colour
// gating, optional pattern) and a small-raster instance (full-frame behaviour).
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       rst;
  logic [2:0] pix_r, pix_g;
  logic [1:0] pix_b;
  logic       pattern_sel;

  logic [10:0] d_x, d_y;
  logic        d_pix_ce, d_HS, d_VS, d_de, d_fs;
  logic [2:0]  d_R, d_G;
  logic [1:0]  d_B;

  logic [3:0]  s_x, s_y;
  logic        s_pix_ce, s_HS, s_VS, s_de, s_fs;
  logic [2:0]  s_R, s_G;
  logic [1:0]  s_B;

  vga_timing_gen dut_d (
    .clk(clk), .rst(rst), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .pattern_sel(pattern_sel), .x(d_x), .y(d_y), .pix_ce(d_pix_ce),
    .R(d_R), .G(d_G), .B(d_B), .HS(d_HS), .VS(d_VS), .de(d_de),
    .frame_start(d_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1), .VS_POL(0), .CLK_DIV(1), .CNT_W(4)
  ) dut_s (
    .clk(clk), .rst(rst), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .pattern_sel(pattern_sel), .x(s_x), .y(s_y), .pix_ce(s_pix_ce),
    .R(s_R), .G(s_G), .B(s_B), .HS(s_HS), .VS(s_VS), .de(s_de),
    .frame_start(s_fs)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] vx, vy;
    logic [2:0] ir, ig;
    logic [1:0] ib;
    logic       hs, vs, de;
    logic [2:0] er, eg;
    logic [1:0] eb;
  } vec_t;

  vec_t tbl[11];

  // Wait (at negedges) until the small instance presents (vx,vy) on a pixel tick.
  task automatic wait_s(input logic [3:0] vx, input logic [3:0] vy, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (s_pix_ce && s_x == vx && s_y == vy) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  // Wait (at negedges) until the default instance presents column vx on a pixel tick.
  task automatic wait_d(input logic [10:0] vx, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (d_pix_ce && d_x == vx) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int cnt, per, den, vsl, hsh, low, tot, bad, pairs;
    bit seen_high;
    logic [2:0] xr, xg;
    logic [1:0] xb;

    rst = 1'b0; pix_r = 3'd7; pix_g = 3'd0; pix_b = 2'd3; pattern_sel = 1'b0;

    tbl[0]  = '{4'd0,  4'd0, 3'd7, 3'd0, 2'd3, 1'b0, 1'b1, 1'b1, 3'd7, 3'd0, 2'd3};
    tbl[1]  = '{4'd7,  4'd0, 3'd1, 3'd2, 2'd1, 1'b0, 1'b1, 1'b1, 3'd1, 3'd2, 2'd1};
    tbl[2]  = '{4'd8,  4'd0, 3'd7, 3'd7, 2'd3, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 2'd0};
    tbl[3]  = '{4'd10, 4'd0, 3'd7, 3'd7, 2'd3, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 2'd0};
    tbl[4]  = '{4'd11, 4'd0, 3'd5, 3'd5, 2'd2, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 2'd0};
    tbl[5]  = '{4'd12, 4'd0, 3'd5, 3'd5, 2'd2, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 2'd0};
    tbl[6]  = '{4'd3,  4'd3, 3'd5, 3'd6, 2'd2, 1'b0, 1'b1, 1'b1, 3'd5, 3'd6, 2'd2};
    tbl[7]  = '{4'd3,  4'd4, 3'd5, 3'd6, 2'd2, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 2'd0};
    tbl[8]  = '{4'd0,  4'd5, 3'd7, 3'd7, 2'd3, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 2'd0};
    tbl[9]  = '{4'd10, 4'd5, 3'd7, 3'd7, 2'd3, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 2'd0};
    tbl[10] = '{4'd13, 4'd6, 3'd7, 3'd7, 2'd3, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 2'd0};

    // Reset values while held, then release latency of pix_ce and frame_start.
    repeat (3) @(negedge clk);
    check("rst_d_pix_ce", d_pix_ce, 0);
    check("rst_d_x", d_x, 0);
    check("rst_d_HS", d_HS, 1);
    check("rst_d_VS", d_VS, 1);
    check("rst_s_HS", s_HS, 0);
    check("rst_s_de", s_de, 0);
    rst = 1'b1;
    @(negedge clk);
    check("rel1_d_pix_ce", d_pix_ce, 0);
    check("rel1_s_pix_ce", s_pix_ce, 1);
    @(negedge clk);
    check("rel2_d_pix_ce", d_pix_ce, 1);
    check("rel2_d_fs", d_fs, 0);
    check("rel2_s_fs", s_fs, 1);
    @(negedge clk);
    check("rel3_d_fs", d_fs, 1);
    check("rel3_d_x", d_x, 1);
    check("rel3_s_fs", s_fs, 0);
    @(negedge clk);
    check("rel4_d_fs", d_fs, 0);

    // Small raster: table of coordinates and the stage-2 outputs one tick later.
    do_reset();
    @(negedge clk);
    foreach (tbl[i]) begin
      pix_r = tbl[i].ir; pix_g = tbl[i].ig; pix_b = tbl[i].ib;
      wait_s(tbl[i].vx, tbl[i].vy, ok);
      if (!ok) check($sformatf("vec%0d_timeout", i), 0, 1);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d_HS", i), s_HS, tbl[i].hs);
      check($sformatf("vec%0d_VS", i), s_VS, tbl[i].vs);
      check($sformatf("vec%0d_de", i), s_de, tbl[i].de);
      check($sformatf("vec%0d_RGB", i), {s_R, s_G, s_B}, {tbl[i].er, tbl[i].eg, tbl[i].eb});
    end
    // Last vector was (13,6): coordinates must now have wrapped to (0,0).
    check("wrap_x", s_x, 0);
    check("wrap_y", s_y, 0);
    check("wrap_fs_early", s_fs, 0);
    @(negedge clk);
    check("wrap_fs", s_fs, 1);
    per = 0; den = 0; vsl = 0; hsh = 0;
    for (int i = 0; i < 300; i++) begin
      per++;
      if (s_de) den++;
      if (!s_VS) vsl++;
      if (s_HS) hsh++;
      @(negedge clk);
      if (s_fs) break;
    end
    check("s_frame_period", per, 98);
    check("s_de_per_frame", den, 32);
    check("s_vs_low_clks", vsl, 14);
    check("s_hs_high_clks", hsh, 14);

    // Default raster: pix_ce cadence, HS timing, de count and colour gating.
    pix_r = 3'd7; pix_g = 3'd0; pix_b = 2'd3; pattern_sel = 1'b0;
    do_reset();
    repeat (4) @(negedge clk);
    cnt = 0; pairs = 0;
    for (int i = 0; i < 10; i++) begin
      if (d_pix_ce) cnt++;
      @(negedge clk);
      if (d_pix_ce && cnt > 0 && i < 9) pairs = pairs + 0;
    end
    check("d_pix_ce_per_10clk", cnt, 5);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      xr = {2'b00, d_pix_ce};
      @(negedge clk);
      if (xr[0] && d_pix_ce) pairs++;
    end
    check("d_pix_ce_back_to_back", pairs, 0);

    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (!d_HS) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("hs_fall_seen", ok, 1);
    check("hs_fall_x", d_x, 657);
    check("hs_fall_y", d_y, 0);
    low = 0; tot = 0; den = 0; bad = 0; seen_high = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (!d_HS && !seen_high) low++;
      if (d_HS) seen_high = 1'b1;
      if (seen_high && !d_HS) break;
      tot++;
      if (d_de) begin
        den++;
        if (d_R != 3'd7 || d_G != 3'd0 || d_B != 2'd3) bad++;
      end else if (d_R != 3'd0 || d_G != 3'd0 || d_B != 2'd0) begin
        bad++;
      end
      @(negedge clk);
    end
    check("hs_low_clks", low, 192);
    check("hs_period_clks", tot, 1600);
    check("de_clks_per_line", den, 1280);
    check("rgb_gating_errors", bad, 0);

    // Colour source with pattern_sel=1 at bar boundaries.
    pattern_sel = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [10:0] cx;
      cx = (i == 0) ? 11'd5 : (i == 1) ? 11'd79 : (i == 2) ? 11'd80 : 11'd560;
`ifdef VGA_TEST_PATTERN_EN
      xr = (i == 3) ? 3'd7 : 3'd0;
      xg = (i == 3) ? 3'd7 : 3'd0;
      xb = (i >= 2) ? 2'd3 : 2'd0;
`else
      xr = 3'd7; xg = 3'd0; xb = 2'd3;
`endif
      wait_d(cx, ok);
      if (!ok) check($sformatf("bar%0d_timeout", i), 0, 1);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("bar_x%0d_RGB", cx), {d_R, d_G, d_B}, {xr, xg, xb});
    end
    pattern_sel = 1'b0;

    // Asynchronous reset mid-line while de is high.
    wait_d(11'd300, ok);
    if (!ok) check("mid_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    check("mid_pre_de", d_de, 1);
    #3 rst = 1'b0;
    #1;
    check("async_d_x", d_x, 0);
    check("async_d_y", d_y, 0);
    check("async_d_pix_ce", d_pix_ce, 0);
    check("async_d_de", d_de, 0);
    check("async_d_RGB", {d_R, d_G, d_B}, 0);
    check("async_d_HS", d_HS, 1);
    check("async_d_VS", d_VS, 1);
    check("async_d_fs", d_fs, 0);
    check("async_s_HS", s_HS, 0);
    check("async_s_xy", {s_x, s_y}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cnt++;
      if (d_fs) break;
    end
    check("post_rst_fs_clks", cnt, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
